// File: rtl/acc_alu_seq.sv
// Accumulator ALU with single-cycle arithmetic/logic ops and iterative
// shift-add multiply / restoring divide behind a valid/ready handshake.
module acc_alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_hi,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             dz,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    localparam logic [3:0] OpNoop  = 4'd0;
    localparam logic [3:0] OpReset = 4'd1;
    localparam logic [3:0] OpAdd   = 4'd2;
    localparam logic [3:0] OpSub   = 4'd3;
    localparam logic [3:0] OpMul   = 4'd4;
    localparam logic [3:0] OpDiv   = 4'd5;
    localparam logic [3:0] OpAnd   = 4'd6;
    localparam logic [3:0] OpOr    = 4'd7;
    localparam logic [3:0] OpNot   = 4'd8;
    localparam logic [3:0] OpXor   = 4'd9;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    // Working registers keep acc/acc_hi untouched until the final iteration.
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_op;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;

    assign in_ready = (state == StIdle);

    assign add_sum  = {1'b0, acc} + {1'b0, a};
    assign sub_diff = {1'b0, acc} - {1'b0, a};

    always_comb begin
        logic_res = acc;
        case (opcode)
            OpAnd:   logic_res = acc & a;
            OpOr:    logic_res = acc | a;
            OpXor:   logic_res = acc ^ a;
            OpNot:   logic_res = ~acc;
            default: logic_res = acc;
        endcase
    end

    // Shift-add step: conditionally add multiplicand, then shift {hi,lo} right.
    assign mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_op} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], w_lo[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into remainder, subtract if it fits.
    assign div_shift = {w_hi, w_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, w_op});
    assign div_trial = div_shift - {1'b0, w_op};
    assign div_hi_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_nx = {w_lo[WIDTH-2:0], div_ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            w_hi    <= '0;
            w_lo    <= '0;
            w_op    <= '0;
            acc     <= '0;
            acc_hi  <= '0;
            done    <= 1'b0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            dz      <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        illegal <= (opcode > OpXor);
                        case (opcode)
                            OpNoop: done <= 1'b1;
                            OpReset: begin
                                acc     <= '0;
                                acc_hi  <= '0;
                                carry   <= 1'b0;
                                zero    <= 1'b0;
                                dz      <= 1'b0;
                                illegal <= 1'b0;
                                done    <= 1'b1;
                            end
                            OpAdd: begin
                                acc   <= add_sum[WIDTH-1:0];
                                carry <= add_sum[WIDTH];
                                zero  <= (add_sum[WIDTH-1:0] == '0);
                                dz    <= 1'b0;
                                done  <= 1'b1;
                            end
                            OpSub: begin
                                acc   <= sub_diff[WIDTH-1:0];
                                carry <= sub_diff[WIDTH];
                                zero  <= (sub_diff[WIDTH-1:0] == '0);
                                dz    <= 1'b0;
                                done  <= 1'b1;
                            end
                            OpMul: begin
                                w_hi  <= '0;
                                w_lo  <= a;
                                w_op  <= acc;
                                cnt   <= '0;
                                state <= StMul;
                            end
                            OpDiv: begin
                                if (a == '0) begin
                                    acc    <= '1;
                                    acc_hi <= acc;
                                    carry  <= 1'b0;
                                    zero   <= 1'b0;
                                    dz     <= 1'b1;
                                    done   <= 1'b1;
                                end else begin
                                    w_hi  <= '0;
                                    w_lo  <= acc;
                                    w_op  <= a;
                                    cnt   <= '0;
                                    state <= StDiv;
                                end
                            end
                            OpAnd, OpOr, OpNot, OpXor: begin
                                acc   <= logic_res;
                                carry <= 1'b0;
                                zero  <= (logic_res == '0);
                                dz    <= 1'b0;
                                done  <= 1'b1;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                StMul: begin
                    w_hi <= mul_hi_nx;
                    w_lo <= mul_lo_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        acc    <= mul_lo_nx;
                        acc_hi <= mul_hi_nx;
                        carry  <= |mul_hi_nx;
                        zero   <= (mul_lo_nx == '0);
                        dz     <= 1'b0;
                        done   <= 1'b1;
                        state  <= StIdle;
                    end
                end
                StDiv: begin
                    w_hi <= div_hi_nx;
                    w_lo <= div_lo_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        acc    <= div_lo_nx;
                        acc_hi <= div_hi_nx;
                        carry  <= 1'b0;
                        zero   <= (div_lo_nx == '0);
                        dz     <= 1'b0;
                        done   <= 1'b1;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed self-checking bench for acc_alu_seq at WIDTH=16.
module tb_acc_alu_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_hi;
    logic             done;
    logic             carry;
    logic             zero;
    logic             dz;
    logic             illegal;

    int checks = 0;
    int errors = 0;
    int n_cyc;
    int n_low;

    acc_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .a        (a),
        .acc      (acc),
        .acc_hi   (acc_hi),
        .done     (done),
        .carry    (carry),
        .zero     (zero),
        .dz       (dz),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; sample #1 after that edge.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] val);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        a        = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until done, optionally pulsing a stray ADD while busy.
    task automatic wait_done(input bit pulse, output int cyc, output int low);
        cyc = 0;
        low = in_ready ? 0 : 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (pulse && cyc == 3) begin
                in_valid = 1'b1;
                opcode   = 4'd2;
                a        = 16'h0001;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!in_ready) low++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        opcode   = 4'd0;
        a        = '0;
        #12;
        chk("rst_acc", acc, 0);
        chk("rst_acc_hi", acc_hi, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {carry, zero, dz, illegal}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        issue(4'd0, 16'h0000);
        chk("noop_done", done, 1);
        chk("noop_acc", acc, 0);
        issue(4'd2, 16'h0005);
        chk("add5_acc", acc, 16'h0005);
        chk("add5_carry", carry, 0);
        chk("add5_done", done, 1);
        issue(4'd2, 16'hFFFE);
        chk("addwrap_acc", acc, 16'h0003);
        chk("addwrap_carry", carry, 1);
        chk("addwrap_zero", zero, 0);
        @(posedge clk);
        #1;
        chk("idle_done", done, 0);

        issue(4'd3, 16'h0005);
        chk("sub_borrow_acc", acc, 16'hFFFE);
        chk("sub_borrow_carry", carry, 1);
        issue(4'd3, 16'hFFFE);
        chk("sub_zero_acc", acc, 16'h0000);
        chk("sub_zero_zero", zero, 1);
        chk("sub_zero_carry", carry, 0);

        issue(4'd2, 16'h1234);
        chk("load_1234", acc, 16'h1234);
        issue(4'd4, 16'h0100);
        chk("mul_busy_ready", in_ready, 0);
        chk("mul_busy_done", done, 0);
        chk("mul_busy_acc", acc, 16'h1234);
        wait_done(1'b1, n_cyc, n_low);
        chk("mul_latency", n_cyc, 16);
        chk("mul_ready_low", n_low, 16);
        chk("mul_ready_after", in_ready, 1);
        chk("mul_acc", acc, 16'h3400);
        chk("mul_acc_hi", acc_hi, 16'h0012);
        chk("mul_carry", carry, 1);
        chk("mul_zero", zero, 0);
        @(posedge clk);
        #1;
        chk("mul_no_extra_done", done, 0);
        chk("mul_stray_ignored", acc, 16'h3400);

        issue(4'd1, 16'h0000);
        chk("reset_op_acc", acc, 0);
        chk("reset_op_acc_hi", acc_hi, 0);
        chk("reset_op_carry", carry, 0);
        chk("reset_op_done", done, 1);
        issue(4'd2, 16'd100);
        chk("load_100", acc, 16'd100);
        issue(4'd5, 16'd7);
        wait_done(1'b0, n_cyc, n_low);
        chk("div_latency", n_cyc, 16);
        chk("div_quot", acc, 16'd14);
        chk("div_rem", acc_hi, 16'd2);
        chk("div_carry", carry, 0);
        issue(4'd5, 16'd0);
        chk("dz_done", done, 1);
        chk("dz_ready", in_ready, 1);
        chk("dz_acc", acc, 16'hFFFF);
        chk("dz_acc_hi", acc_hi, 16'd14);
        chk("dz_flag", dz, 1);
        issue(4'd2, 16'h0001);
        chk("dz_clear", dz, 0);
        chk("add_after_dz_acc", acc, 16'h0000);
        chk("add_after_dz_flags", {carry, zero}, 2'b11);

        issue(4'd1, 16'h0000);
        issue(4'd2, 16'h00F0);
        issue(4'd6, 16'h0FF0);
        chk("and_acc", acc, 16'h00F0);
        chk("and_done", done, 1);
        issue(4'd7, 16'h000F);
        chk("or_acc", acc, 16'h00FF);
        chk("or_done", done, 1);
        issue(4'd9, 16'h00FF);
        chk("xor_acc", acc, 16'h0000);
        chk("xor_zero", zero, 1);
        issue(4'd8, 16'h1234);
        chk("not_acc", acc, 16'hFFFF);
        chk("not_zero", zero, 0);
        chk("not_done", done, 1);
        issue(4'd12, 16'h5555);
        chk("illegal_flag", illegal, 1);
        chk("illegal_acc", acc, 16'hFFFF);
        chk("illegal_done", done, 1);
        issue(4'd0, 16'h0000);
        chk("illegal_clear", illegal, 0);

        issue(4'd4, 16'h0003);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_acc", acc, 0);
        chk("abort_acc_hi", acc_hi, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", {carry, zero, dz, illegal}, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_abort_ready", in_ready, 1);
        issue(4'd2, 16'h0001);
        chk("post_abort_acc", acc, 16'h0001);
        chk("post_abort_done", done, 1);
        @(posedge clk);
        #1;
        chk("post_abort_quiet", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
